// File: rtl/kmeans_pkg.sv
// kmeans_pkg: shared states, register map
// and helpers for the k-means sequencer.
package kmeans_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LD_RD,
    LD_WR,
    RD_PTS,
    DRAIN,
    CALC,
    CNVG_WAIT,
    WRBACK,
    DONE
  } state_e;

  localparam int STATUS_REG    = 0;
  localparam int GO_REG        = 1;
  localparam int CENT_REG_BASE = 2;

  function automatic logic [31:0] onehot(
    input logic [31:0] i
  );
    return 32'd1 << i;
  endfunction

endpackage

// File: rtl/kmeans_ctrl_v2_if.sv
// kmeans_ctrl_v2_if: register-file and point
// RAM bus driven by the sequencer.
interface kmeans_ctrl_v2_if #(
  parameter int ADDR_W = 9,
  parameter int REG_W  = 4
);
  logic [REG_W-1:0]  reg_num;
  logic              reg_write;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_cs_n;
  logic              ram_oe_n;
  logic              ram_we_n;

  modport master (
    output reg_num, reg_write, ram_addr,
    output ram_cs_n, ram_oe_n, ram_we_n
  );

  modport slave (
    input reg_num, reg_write, ram_addr,
    input ram_cs_n, ram_oe_n, ram_we_n
  );
endinterface

// File: rtl/kmeans_issue_tracker.sv
// kmeans_issue_tracker: point address counter
// and in-flight issue shift register.
module kmeans_issue_tracker
  import kmeans_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int PIPE_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] end_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o,
  output logic              valid_o,
  output logic              empty_o
);

  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [PIPE_DEPTH-1:0] sr_q, sr_d;

  assign addr_o  = addr_q;
  assign last_o  = (addr_q == end_i);
  assign valid_o = sr_q[PIPE_DEPTH-1];
  assign empty_o = (sr_q == '0);

  // advance address per issue, never past end
  always_comb begin
    addr_d = addr_q;
    if (load_i)
      addr_d = base_i;
    else if (issue_i && !last_o)
      addr_d = addr_q + ADDR_W'(1);
    sr_d = (sr_q << 1) | PIPE_DEPTH'(issue_i);
    if (flush_i)
      sr_d = '0;
  end

  // address and issue-valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      sr_q   <= '0;
    end else begin
      addr_q <= addr_d;
      sr_q   <= sr_d;
    end
  end

endmodule

// File: rtl/kmeans_ctrl_v2.sv
// kmeans_ctrl_v2: k-means sequencer - load,
// stream points, divide, converge, write back.
module kmeans_ctrl_v2
  import kmeans_pkg::*;
#(
  parameter int CENT_MAX      = 8,
  parameter int LOG2_CENT     = 3,
  parameter int ADDR_W        = 9,
  parameter int PIPE_DEPTH    = 3,
  parameter int ITER_W        = 8,
  parameter int REG_W         = 4,
  parameter int CENT_REG_BASE = kmeans_pkg::CENT_REG_BASE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go_i,
  input  logic                 abort_i,
  input  logic [LOG2_CENT:0]   cfg_cent_num_i,
  input  logic [ADDR_W-1:0]    first_addr_i,
  input  logic [ADDR_W-1:0]    last_addr_i,
  input  logic [ITER_W-1:0]    max_iter_i,
  kmeans_ctrl_v2_if.master     bus,
  output logic [CENT_MAX-1:0]  cent_en_o,
  output logic                 first_iter_o,
  output logic                 accum_en_o,
  output logic                 pipe_clr_o,
  output logic                 div_en_o,
  output logic [LOG2_CENT-1:0] cent_idx_o,
  output logic                 cnvg_en_o,
  output logic                 cnvg_clr_o,
  input  logic                 cnvg_valid_i,
  input  logic                 has_converged_i,
  output logic                 busy_o,
  output logic [ITER_W-1:0]    iter_cnt_o,
  output logic                 timed_out_o,
  output logic                 cfg_err_o,
  output logic                 done_o
);

  localparam int KW = LOG2_CENT + 1;

  state_e               state_q, state_d;
  logic [LOG2_CENT-1:0] idx_q, idx_d;
  logic [KW-1:0]        k_q, k_d;
  logic [ADDR_W-1:0]    first_q, first_d;
  logic [ADDR_W-1:0]    last_q, last_d;
  logic [ITER_W-1:0]    maxit_q, maxit_d;
  logic [ITER_W-1:0]    iter_q, iter_d;
  logic                 timed_q, timed_d;
  logic                 err_q, err_d;
  logic                 errp_q, errp_d;
  logic                 fiter_q, fiter_d;
  logic                 entry_q, entry_d;

  logic              load, issue, idx_last, cfg_bad;
  logic              trk_last, trk_empty;
  logic [ADDR_W-1:0] trk_addr;

  assign issue    = (state_q == RD_PTS) && !abort_i;
  assign idx_last = ({1'b0, idx_q} + KW'(1)) == k_q;
  assign cfg_bad  = (cfg_cent_num_i == '0)
                 || (cfg_cent_num_i > KW'(CENT_MAX))
                 || (last_addr_i < first_addr_i);

  kmeans_issue_tracker #(
    .ADDR_W    (ADDR_W),
    .PIPE_DEPTH(PIPE_DEPTH)
  ) u_trk (
    .clk    (clk),
    .rst    (rst),
    .flush_i(abort_i),
    .load_i (load),
    .issue_i(issue),
    .base_i (first_q),
    .end_i  (last_q),
    .addr_o (trk_addr),
    .last_o (trk_last),
    .valid_o(accum_en_o),
    .empty_o(trk_empty)
  );

  // sequencing and status next-state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    k_d     = k_q;
    first_d = first_q;
    last_d  = last_q;
    maxit_d = maxit_q;
    iter_d  = iter_q;
    timed_d = timed_q;
    err_d   = err_q;
    errp_d  = 1'b0;
    fiter_d = fiter_q;
    entry_d = 1'b0;
    load    = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (go_i) begin
          timed_d = 1'b0;
          iter_d  = '0;
          idx_d   = '0;
          err_d   = cfg_bad;
          errp_d  = cfg_bad;
          if (!cfg_bad) begin
            fiter_d = 1'b1;
            k_d     = cfg_cent_num_i;
            first_d = first_addr_i;
            last_d  = last_addr_i;
            maxit_d = (max_iter_i == '0) ?
                      ITER_W'(1) : max_iter_i;
            state_d = LD_RD;
          end
        end
        LD_RD: state_d = LD_WR;
        LD_WR: if (idx_last) begin
          idx_d   = '0;
          load    = 1'b1;
          entry_d = 1'b1;
          state_d = RD_PTS;
        end else begin
          idx_d   = idx_q + LOG2_CENT'(1);
          state_d = LD_RD;
        end
        RD_PTS: begin
          if (entry_q) fiter_d = 1'b0;
          if (trk_last) state_d = DRAIN;
        end
        DRAIN: if (trk_empty) state_d = CALC;
        CALC: if (idx_last) begin
          idx_d   = '0;
          state_d = CNVG_WAIT;
        end else begin
          idx_d = idx_q + LOG2_CENT'(1);
        end
        CNVG_WAIT: if (cnvg_valid_i) begin
          iter_d = iter_q + ITER_W'(1);
          if (has_converged_i) begin
            state_d = WRBACK;
          end else if (({1'b0, iter_q} + (ITER_W+1)'(1))
                       >= {1'b0, maxit_q}) begin
            timed_d = 1'b1;
            state_d = WRBACK;
          end else begin
            load    = 1'b1;
            entry_d = 1'b1;
            state_d = RD_PTS;
          end
        end
        WRBACK: if (idx_last) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + LOG2_CENT'(1);
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // state and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      k_q     <= '0;
      first_q <= '0;
      last_q  <= '0;
      maxit_q <= '0;
      iter_q  <= '0;
      timed_q <= 1'b0;
      err_q   <= 1'b0;
      errp_q  <= 1'b0;
      fiter_q <= 1'b1;
      entry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      first_q <= first_d;
      last_q  <= last_d;
      maxit_q <= maxit_d;
      iter_q  <= iter_d;
      timed_q <= timed_d;
      err_q   <= err_d;
      errp_q  <= errp_d;
      fiter_q <= fiter_d;
      entry_q <= entry_d;
    end
  end

  // per-state strobes and bus decode
  always_comb begin
    bus.reg_num   = '0;
    bus.reg_write = 1'b0;
    cent_en_o     = '0;
    cent_idx_o    = '0;
    div_en_o      = 1'b0;
    cnvg_en_o     = 1'b0;
    cnvg_clr_o    = 1'b0;
    pipe_clr_o    = 1'b0;
    unique case (1'b1)
      state_q == LD_RD: begin
        bus.reg_num = REG_W'(CENT_REG_BASE + 32'(idx_q));
      end
      state_q == LD_WR: begin
        cent_en_o  = CENT_MAX'(onehot(32'(idx_q)));
        cent_idx_o = idx_q;
      end
      state_q == RD_PTS: begin
        pipe_clr_o = entry_q;
        cnvg_clr_o = entry_q;
      end
      state_q == CALC: begin
        div_en_o   = 1'b1;
        cnvg_en_o  = 1'b1;
        cent_en_o  = CENT_MAX'(onehot(32'(idx_q)));
        cent_idx_o = idx_q;
      end
      state_q == WRBACK: begin
        bus.reg_write = 1'b1;
        bus.reg_num   = REG_W'(CENT_REG_BASE + 32'(idx_q));
      end
      default: ;
    endcase
  end

  assign bus.ram_addr = trk_addr;
  assign bus.ram_cs_n = (state_q != RD_PTS);
  assign bus.ram_oe_n = (state_q != RD_PTS);
  assign bus.ram_we_n = 1'b1;
  assign first_iter_o = fiter_q;
  assign busy_o       = (state_q != IDLE);
  assign iter_cnt_o   = iter_q;
  assign timed_out_o  = timed_q;
  assign cfg_err_o    = err_q;
  assign done_o       = (state_q == DONE) || errp_q;

endmodule

// File: tb/tb_kmeans_ctrl_v2.sv
// tb_kmeans_ctrl_v2: randomized and directed
// runs checked against an arithmetic model.
module tb_kmeans_ctrl_v2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cfg = '0;
  logic [8:0] fa = '0;
  logic [8:0] la = '0;
  logic [7:0] mi = '0;
  logic       cnvg_valid = 1'b0;
  logic       has_conv;
  logic [7:0] cent_en;
  logic       first_iter, accum_en, pipe_clr, div_en;
  logic [2:0] cent_idx;
  logic       cnvg_en, cnvg_clr, busy;
  logic [7:0] iter_cnt;
  logic       timed_out, cfg_err, done;

  int checks = 0;
  int errors = 0;
  int conv_pass = 255;

  kmeans_ctrl_v2_if #(.ADDR_W(9), .REG_W(4)) bus ();

  kmeans_ctrl_v2 dut (
    .clk            (clk),
    .rst            (rst),
    .go_i           (go),
    .abort_i        (abort),
    .cfg_cent_num_i (cfg),
    .first_addr_i   (fa),
    .last_addr_i    (la),
    .max_iter_i     (mi),
    .bus            (bus),
    .cent_en_o      (cent_en),
    .first_iter_o   (first_iter),
    .accum_en_o     (accum_en),
    .pipe_clr_o     (pipe_clr),
    .div_en_o       (div_en),
    .cent_idx_o     (cent_idx),
    .cnvg_en_o      (cnvg_en),
    .cnvg_clr_o     (cnvg_clr),
    .cnvg_valid_i   (cnvg_valid),
    .has_converged_i(has_conv),
    .busy_o         (busy),
    .iter_cnt_o     (iter_cnt),
    .timed_out_o    (timed_out),
    .cfg_err_o      (cfg_err),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  // observation log
  logic mon_clr = 1'b0;
  int   cyc = 0;
  int   ld_reg[$], ld_cent[$], ld_idx[$];
  int   calc_cent[$], calc_idx[$], wb_reg[$];
  int   addr_q[$], issue_t[$], acc_t[$];
  int   pass_cnt = 0, clr_cnt = 0, done_cnt = 0;
  int   cnv_cnt = 0, busy_cnt = 0;
  int   we_bad = 0, oe_bad = 0;

  assign has_conv = (pass_cnt >= conv_pass);

  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      ld_reg.delete(); ld_cent.delete();
      ld_idx.delete(); calc_cent.delete();
      calc_idx.delete(); wb_reg.delete();
      addr_q.delete(); issue_t.delete();
      acc_t.delete();
      pass_cnt = 0; clr_cnt = 0; done_cnt = 0;
      cnv_cnt = 0; busy_cnt = 0;
      we_bad = 0; oe_bad = 0;
    end else begin
      if (bus.reg_num != 0 && !bus.reg_write)
        ld_reg.push_back(int'(bus.reg_num));
      if (bus.reg_write)
        wb_reg.push_back(int'(bus.reg_num));
      if (cent_en != 0 && !div_en) begin
        ld_cent.push_back(int'(cent_en));
        ld_idx.push_back(int'(cent_idx));
      end
      if (div_en) begin
        calc_cent.push_back(int'(cent_en));
        calc_idx.push_back(int'(cent_idx));
      end
      if (cnvg_en) cnv_cnt++;
      if (!bus.ram_cs_n) begin
        addr_q.push_back(int'(bus.ram_addr));
        issue_t.push_back(cyc);
      end
      if (accum_en) acc_t.push_back(cyc);
      if (bus.ram_oe_n != bus.ram_cs_n) oe_bad++;
      if (!bus.ram_we_n) we_bad++;
      if (pipe_clr) pass_cnt++;
      if (cnvg_clr) clr_cnt++;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
  end

  // convergence unit answers after random delay
  always @(negedge clk)
    cnvg_valid = ($urandom_range(0, 2) == 0);

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    @(posedge clk);
    mon_clr = 1'b1;
    @(posedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic start(input int k, input int f,
                       input int l, input int m);
    @(negedge clk);
    cfg = 4'(k); fa = 9'(f); la = 9'(l);
    mi = 8'(m); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt != 0, 1);
  endtask

  task automatic check_run(input string tag,
                           input int k, input int f,
                           input int l, input int m,
                           input int c, input bit busy_go);
    int n    = l - f + 1;
    int meff = (m == 0) ? 1 : m;
    int it   = (c < meff) ? c : meff;
    bit to   = (c > meff);
    clear_mon();
    conv_pass = c;
    start(k, f, l, m);
    if (busy_go) begin
      repeat (4) @(negedge clk);
      cfg = 4'd2; fa = 9'd0; la = 9'd100;
      mi = 8'd1; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
    wait_done(tag);
    settle(3);
    chk({tag, "_ld_n"}, ld_reg.size(), k);
    foreach (ld_reg[i])
      chk({tag, "_ld_reg"}, ld_reg[i], 2 + i);
    chk({tag, "_ldc_n"}, ld_cent.size(), k);
    foreach (ld_cent[i]) begin
      chk({tag, "_ld_cent"}, ld_cent[i], 1 << i);
      chk({tag, "_ld_idx"}, ld_idx[i], i);
    end
    chk({tag, "_calc_n"}, calc_cent.size(), it * k);
    foreach (calc_cent[j]) begin
      chk({tag, "_calc_cent"}, calc_cent[j],
          1 << (j % k));
      chk({tag, "_calc_idx"}, calc_idx[j], j % k);
    end
    chk({tag, "_cnvg_en_n"}, cnv_cnt, it * k);
    chk({tag, "_wb_n"}, wb_reg.size(), k);
    foreach (wb_reg[i])
      chk({tag, "_wb_reg"}, wb_reg[i], 2 + i);
    chk({tag, "_rd_n"}, addr_q.size(), it * n);
    foreach (addr_q[j])
      chk({tag, "_addr"}, addr_q[j], f + (j % n));
    chk({tag, "_acc_n"}, acc_t.size(), it * n);
    foreach (acc_t[j])
      if (j < issue_t.size())
        chk({tag, "_acc_lat"}, acc_t[j] - issue_t[j], 3);
    chk({tag, "_passes"}, pass_cnt, it);
    chk({tag, "_cnvg_clr"}, clr_cnt, it);
    chk({tag, "_done_n"}, done_cnt, 1);
    chk({tag, "_we"}, we_bad, 0);
    chk({tag, "_oe"}, oe_bad, 0);
    chk({tag, "_iter"}, iter_cnt, it);
    chk({tag, "_timeout"}, timed_out, to);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_first_iter"}, first_iter, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_reg_num"}, bus.reg_num, 0);
    chk({tag, "_reg_write"}, bus.reg_write, 0);
    chk({tag, "_ram_addr"}, bus.ram_addr, 0);
    chk({tag, "_cs_n"}, bus.ram_cs_n, 1);
    chk({tag, "_oe_n"}, bus.ram_oe_n, 1);
    chk({tag, "_we_n"}, bus.ram_we_n, 1);
    chk({tag, "_cent_en"}, cent_en, 0);
    chk({tag, "_first_iter"}, first_iter, 1);
    chk({tag, "_accum"}, accum_en, 0);
    chk({tag, "_strobes"},
        {pipe_clr, div_en, cnvg_en, cnvg_clr}, 0);
    chk({tag, "_cent_idx"}, cent_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_iter"}, iter_cnt, 0);
    chk({tag, "_status"}, {timed_out, cfg_err, done}, 0);
  endtask

  task automatic check_bad(input string tag,
                           input int k, input int f,
                           input int l);
    clear_mon();
    start(k, f, l, 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cfg_err"}, cfg_err, 1);
    chk({tag, "_busy"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_once"}, done, 0);
    settle(4);
    chk({tag, "_busy_cycles"}, busy_cnt, 0);
    chk({tag, "_ram"}, addr_q.size(), 0);
    chk({tag, "_cfg_err_hold"}, cfg_err, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    check_run("k8", 8, 0, 9, 5, 1, 1'b0);
    check_run("k3n1", 3, 5, 5, 3, 1, 1'b0);
    check_run("tmo4", 4, 20, 26, 4, 255, 1'b0);
    check_run("iter0", 2, 100, 102, 0, 255, 1'b0);
    check_run("convlim", 5, 7, 9, 3, 3, 1'b0);
    check_run("top", 6, 508, 511, 2, 2, 1'b0);

    // go together with abort while idle
    @(negedge clk);
    cfg = 4'd3; fa = 9'd0; la = 9'd5;
    go = 1'b1; abort = 1'b1;
    clear_mon();
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
    settle(4);
    chk("goabort_busy", busy_cnt, 0);
    chk("goabort_done", done_cnt, 0);
    chk("goabort_iter", iter_cnt, 2);
    chk("goabort_tmo", timed_out, 0);

    check_run("busygo", 5, 40, 47, 3, 2, 1'b1);

    for (int r = 0; r < 6; r++) begin
      int k = $urandom_range(1, 8);
      int f = $urandom_range(0, 500);
      int l = f + $urandom_range(0, 9);
      int m = $urandom_range(0, 4);
      int c = $urandom_range(1, 5);
      check_run($sformatf("rnd%0d", r), k, f, l, m, c,
                1'b0);
    end

    check_bad("k9", 9, 0, 5);
    check_bad("k0", 0, 0, 5);
    check_bad("rev", 4, 30, 29);

    // abort in the middle of a point pass
    clear_mon();
    conv_pass = 255;
    start(4, 10, 40, 3);
    n = 0;
    while (bus.ram_cs_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_rd", bus.ram_cs_n, 0);
    chk("abort_cfg_err_cleared", cfg_err, 0);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cs_n", bus.ram_cs_n, 1);
    chk("abort_oe_n", bus.ram_oe_n, 1);
    chk("abort_accum", accum_en, 0);
    chk("abort_first_iter", first_iter, 0);
    settle(10);
    chk("abort_done", done_cnt, 0);
    chk("abort_iter", iter_cnt, 0);
    chk("abort_acc_stop", acc_t.size() <= issue_t.size(), 1);

    // reset during the second divide pass
    clear_mon();
    conv_pass = 255;
    start(3, 0, 4, 5);
    n = 0;
    while (!(div_en && iter_cnt == 1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reached_calc", div_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("rst_mid");
    settle(8);
    chk("rst_done", done_cnt, 0);
    chk("rst_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
